// File: rtl/ahb_mem_init_pkg.sv
// Shared constants, FSM encoding and the deterministic fill pattern for the
// AHB-lite memory initialiser/checker.
package ahb_mem_init_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] MODE_FILL  = 2'd0;
  localparam logic [1:0] MODE_CHECK = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CHECK = 2'd2,
    ST_TAIL  = 2'd3
  } state_t;

  // Word i carries its index in the top half and the inverted index below,
  // so stuck or swapped address/data lines both show up as mismatches.
  function automatic logic [31:0] pat(input logic [15:0] i16, input logic [31:0] seed);
    return seed ^ {i16, ~i16};
  endfunction

endpackage

// File: rtl/ahb_mem_init_chk.sv
// Read-data compare: tracks the index of the beat in its data phase and keeps
// a saturating mismatch count plus the address of the first mismatch.
module ahb_mem_init_chk
  import ahb_mem_init_pkg::*;
#(
  parameter int          L2MD = 16,
  parameter logic [31:0] SEED = 32'hA5C3_0F96
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clken,
  input  logic            s_ready,
  input  logic            clr,
  input  logic            rd_p0,
  input  logic [L2MD-3:0] idx_p0,
  input  logic [31:0]     s_rdata,
  output logic [31:0]     pat_p1,
  output logic [15:0]     err_count,
  output logic [L2MD-1:0] first_err_addr
);

  localparam int IW = L2MD - 2;

  logic [IW-1:0] i_p1;
  logic          vld_p1;
  logic [15:0]   i16_p1;
  logic          miss_p1;

  // address phase -> data phase
  always_ff @(posedge clk) begin
    if (clken && s_ready) i_p1 <= idx_p0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p1         <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (clken) begin
      if (s_ready) vld_p1 <= rd_p0;
      if (clr) begin
        err_count      <= '0;
        first_err_addr <= '0;
      end else if (s_ready && vld_p1 && miss_p1) begin
        if (err_count != '1) err_count <= err_count + 16'd1;
        if (err_count == '0) first_err_addr <= {i_p1, 2'b00};
      end
    end
  end

  always_comb begin
    i16_p1         = '0;
    i16_p1[IW-1:0] = i_p1;
  end

  assign pat_p1  = pat(i16_p1, SEED);
  assign miss_p1 = (s_rdata != pat_p1);

endmodule

// File: rtl/ahb_mem_init.sv
// Bus-owning fill/check engine placed in front of an AHB-lite SRAM slave;
// transparent to the host whenever it is not running.
module ahb_mem_init
  import ahb_mem_init_pkg::*;
#(
  parameter int          L2MD = 16,
  parameter logic [31:0] SEED = 32'hA5C3_0F96
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clken,
  input  logic            start,
  input  logic [1:0]      mode,
  output logic            busy,
  output logic            done,
  output logic [15:0]     err_count,
  output logic [L2MD-1:0] first_err_addr,
  input  logic [L2MD-1:0] h_addr,
  input  logic [1:0]      h_trans,
  input  logic            h_write,
  input  logic [2:0]      h_size,
  input  logic [31:0]     h_wdata,
  output logic [31:0]     h_rdata,
  output logic            h_ready,
  output logic [L2MD-1:0] s_addr,
  output logic [1:0]      s_trans,
  output logic            s_write,
  output logic [2:0]      s_size,
  output logic [31:0]     s_wdata,
  input  logic [31:0]     s_rdata,
  input  logic            s_ready
);

  localparam int            IW   = L2MD - 2;
  localparam logic [IW-1:0] LAST = '1;

  state_t        state;
  logic [IW-1:0] idx;
  logic          then_check;
  logic          dp_owner;
  logic          start_acc;
  logic          eng_act;
  logic [31:0]   pat_p1;

  assign start_acc = (state == ST_IDLE) && start && clken;
  assign eng_act   = (state == ST_FILL) || (state == ST_CHECK);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      then_check <= 1'b0;
      dp_owner   <= 1'b0;
    end else if (clken) begin
      done <= 1'b0;
      // The data phase belongs to whoever drove the accepted address phase.
      if (s_ready) dp_owner <= busy;
      case (state)
        ST_IDLE: if (start) begin
          state      <= (mode == MODE_CHECK) ? ST_CHECK : ST_FILL;
          then_check <= mode[1];
          idx        <= '0;
          busy       <= 1'b1;
        end
        ST_FILL: if (s_ready) begin
          if (idx == LAST) begin
            idx   <= '0;
            state <= then_check ? ST_CHECK : ST_TAIL;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        ST_CHECK: if (s_ready) begin
          if (idx == LAST) begin
            idx   <= '0;
            state <= ST_TAIL;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        ST_TAIL: if (s_ready) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    if (busy) begin
      s_addr  = {idx, 2'b00};
      s_trans = eng_act ? ((idx == '0) ? HTRANS_NONSEQ : HTRANS_SEQ) : HTRANS_IDLE;
      s_write = (state == ST_FILL);
      s_size  = HSIZE_WORD;
    end else begin
      s_addr  = h_addr;
      s_trans = h_trans;
      s_write = h_write;
      s_size  = h_size;
    end
  end

  assign s_wdata = dp_owner ? pat_p1 : h_wdata;
  assign h_rdata = s_rdata;
  assign h_ready = busy ? 1'b0 : s_ready;

  ahb_mem_init_chk #(
    .L2MD (L2MD),
    .SEED (SEED)
  ) u_chk (
    .clk            (clk),
    .reset_n        (reset_n),
    .clken          (clken),
    .s_ready        (s_ready),
    .clr            (start_acc),
    .rd_p0          (state == ST_CHECK),
    .idx_p0         (idx),
    .s_rdata        (s_rdata),
    .pat_p1         (pat_p1),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

endmodule

// File: tb/tb_ahb_mem_init.sv
// Directed/randomised bench for ahb_mem_init driving a small AHB-lite SRAM model.
module tb_ahb_mem_init;

  localparam int          L2MD = 6;
  localparam int          N    = 16;
  localparam logic [31:0] SEED = 32'hA5C3_0F96;

  logic            clk = 1'b0;
  logic            reset_n, clken, start;
  logic [1:0]      mode;
  logic            busy, done;
  logic [15:0]     err_count;
  logic [L2MD-1:0] first_err_addr;
  logic [L2MD-1:0] h_addr, s_addr;
  logic [1:0]      h_trans, s_trans;
  logic            h_write, s_write;
  logic [2:0]      h_size, s_size;
  logic [31:0]     h_wdata, h_rdata, s_wdata, s_rdata;
  logic            h_ready, s_ready;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_mem [N];

  // SRAM model: address phase registered on ready, write lands in data phase
  logic [31:0] mem [N];
  logic        mem_clr, ap_v, ap_w;
  logic [3:0]  ap_i;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
      ap_v <= 1'b0;
      ap_w <= 1'b0;
      ap_i <= '0;
    end else if (s_ready) begin
      if (ap_v && ap_w) mem[ap_i] <= s_wdata;
      ap_v <= s_trans[1];
      ap_w <= s_write;
      ap_i <= s_addr[5:2];
    end
  end

  assign s_rdata = mem[ap_i];

  ahb_mem_init #(.L2MD(L2MD), .SEED(SEED)) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .start(start), .mode(mode),
    .busy(busy), .done(done), .err_count(err_count), .first_err_addr(first_err_addr),
    .h_addr(h_addr), .h_trans(h_trans), .h_write(h_write), .h_size(h_size),
    .h_wdata(h_wdata), .h_rdata(h_rdata), .h_ready(h_ready),
    .s_addr(s_addr), .s_trans(s_trans), .s_write(s_write), .s_size(s_size),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ready(s_ready)
  );

  function automatic logic [31:0] pat_ref(input int i);
    return SEED ^ ((32'(i) << 16) | (32'(~i) & 32'h0000_FFFF));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input int idx, input logic [31:0] d);
    @(negedge clk);
    h_trans = 2'b10; h_write = 1'b1; h_size = 3'b010; h_addr = L2MD'(idx * 4);
    @(negedge clk);
    h_trans = 2'b00; h_write = 1'b0; h_wdata = d;
    check("host_wr_ready", h_ready, 1);
    ref_mem[idx] = d;
    @(negedge clk);
  endtask

  task automatic host_read(input int idx, output logic [31:0] d);
    @(negedge clk);
    h_trans = 2'b10; h_write = 1'b0; h_size = 3'b010; h_addr = L2MD'(idx * 4);
    @(negedge clk);
    h_trans = 2'b00;
    #1 d = h_rdata;
  endtask

  task automatic run(input logic [1:0] m, input int stall_at, input int stall_len,
                     input bit hw_en, input int hw_idx, input logic [31:0] hw_data);
    int bc, dc, cyc, hr_bad, st_bad, exp_err, exp_first, exp_bc, diffs;
    logic [L2MD-1:0] a0;
    logic [1:0]      t0;
    logic [31:0]     w0;
    bc = 0; dc = 0; cyc = 0; hr_bad = 0; st_bad = 0; diffs = 0;
    a0 = '0; t0 = '0; w0 = '0;
    if (hw_en) ref_mem[hw_idx] = hw_data;
    if (m != 2'd1) for (int i = 0; i < N; i++) ref_mem[i] = pat_ref(i);
    exp_err = 0; exp_first = 0;
    if (m != 2'd0)
      for (int i = 0; i < N; i++)
        if (ref_mem[i] !== pat_ref(i)) begin
          if (exp_err == 0) exp_first = 4 * i;
          exp_err++;
        end
    exp_bc = (m[1] ? 2 * N : N) + 1 + stall_len;

    @(negedge clk);
    start = 1'b1; mode = m;
    if (hw_en) begin
      h_trans = 2'b10; h_write = 1'b1; h_size = 3'b010; h_addr = L2MD'(hw_idx * 4);
    end
    @(negedge clk);
    start = 1'b0; mode = 2'($urandom); h_wdata = hw_data;
    h_trans = 2'b10; h_write = 1'b1; h_addr = L2MD'($urandom);
    #1;
    check("first_trans", s_trans, 2'b10);
    check("first_addr", s_addr, 0);
    check("first_write", s_write, (m != 2'd1));
    while (busy === 1'b1 && cyc < 200) begin
      bc++;
      if (h_ready !== 1'b0) hr_bad++;
      start = 1'($urandom);
      if (bc == stall_at) begin
        s_ready = 1'b0; a0 = s_addr; t0 = s_trans; w0 = s_wdata;
      end else if (stall_len > 0 && bc > stall_at && bc <= stall_at + stall_len) begin
        if (s_addr !== a0 || s_trans !== t0 || s_wdata !== w0) st_bad++;
        if (bc == stall_at + stall_len) s_ready = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (done === 1'b1) dc++;
    end
    start = 1'b0; h_trans = 2'b00; h_write = 1'b0; s_ready = 1'b1;
    check("busy_cycles", bc, exp_bc);
    check("done_seen", dc, 1);
    check("h_ready_low", hr_bad, 0);
    check("stall_hold", st_bad, 0);
    check("err_count", err_count, exp_err);
    check("first_err_addr", first_err_addr, exp_first);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("mem_contents", diffs, 0);
  endtask

  initial begin
    logic [31:0] rd, d;
    int k;
    reset_n = 1'b0; clken = 1'b1; start = 1'b0; mode = 2'd0;
    h_addr = '0; h_trans = 2'b00; h_write = 1'b0; h_size = 3'b010; h_wdata = '0;
    s_ready = 1'b1; mem_clr = 1'b1;
    for (int i = 0; i < N; i++) ref_mem[i] = '0;
    repeat (2) @(negedge clk);
    h_addr = 6'h2C; h_trans = 2'b11; h_write = 1'b1; h_size = 3'b001;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_count, 0);
    check("rst_first", first_err_addr, 0);
    check("rst_pass_addr", s_addr, 6'h2C);
    check("rst_pass_trans", s_trans, 2'b11);
    check("rst_pass_size", s_size, 3'b001);
    check("rst_h_ready", h_ready, 1);
    reset_n = 1'b1; mem_clr = 1'b0; h_trans = 2'b00; h_write = 1'b0; h_size = 3'b010;

    // check on zeroed memory: every word mismatches
    run(2'd1, 0, 0, 1'b0, 0, 32'h0);
    check("zero_err16", err_count, 16);

    // fill+check with a 3-cycle slave stall mid-fill
    run(2'd2, 5, 3, 1'b0, 0, 32'h0);
    host_read(5, rd);
    check("word5", rd, SEED ^ 32'h0005_FFFA);

    // corrupt word 9 through the host port
    host_write(9, pat_ref(9) ^ (32'd1 << $urandom_range(0, 31)));
    run(2'd1, 0, 0, 1'b0, 0, 32'h0);
    check("word9_first", first_err_addr, 6'h24);

    // random corruptions
    for (int j = 0; j < 3; j++) begin
      k = $urandom_range(0, N - 1);
      d = $urandom;
      if (d == pat_ref(k)) d = ~d;
      host_write(k, d);
    end
    run(2'd1, 0, 0, 1'b0, 0, 32'h0);

    // host write issued in the start cycle
    k = $urandom_range(0, N - 1);
    d = $urandom;
    run(2'd1, 0, 0, 1'b1, k, d);

    // random mode and stall
    run(2'($urandom), $urandom_range(2, 10), $urandom_range(1, 3), 1'b0, 0, 32'h0);

    // reset in the middle of a check run
    host_write(0, pat_ref(0) ^ 32'h1);
    @(negedge clk);
    start = 1'b1; mode = 2'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_err_nonzero", (err_count != 16'd0), 1);
    reset_n = 1'b0;
    h_addr = 6'h18; h_trans = 2'b10; h_write = 1'b0;
    @(negedge clk);
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err_count, 0);
    check("abort_pass_addr", s_addr, 6'h18);
    check("abort_pass_trans", s_trans, 2'b10);
    check("abort_pass_write", s_write, 0);
    reset_n = 1'b1; h_trans = 2'b00;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
